// File: rtl/niosqsys_mem_byte_loader.sv
// Byte-stream to 32-bit memory loader.
// Packs incoming bytes little-endian into words.
// Writes each word to consecutive word addresses, starting at a latched base address.
module niosqsys_mem_byte_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        lane;
  logic [31:0]       pack;
  logic [3:0]        fill;
  logic [31:0]       data_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       pack_next;
  logic [3:0]        fill_next;
  logic              word_ready;

  // Merge the incoming byte into its lane and mark that lane as filled
  always_comb begin
    pack_next = pack;
    fill_next = fill;
    pack_next[8*lane +: 8] = in_data;
    fill_next[lane] = 1'b1;
  end

  // A word is flushed when lane 3 fills or the last job byte arrives
  assign word_ready = (lane == 2'd3) || (remaining == CNT_W'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and memory/stream handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    byteenable = 4'b0000;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_next = (byte_count == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && word_ready) state_next = WRITE;
      end
      WRITE: begin
        chipselect = 1'b1;
        write      = 1'b1;
        byteenable = be_q;
        state_next = (remaining == '0) ? DONE : COLLECT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job counters, packing register and the held write word/address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      lane      <= 2'd0;
      pack      <= 32'h0;
      fill      <= 4'b0000;
      data_q    <= 32'h0;
      be_q      <= 4'b0000;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            remaining <= byte_count;
            lane      <= 2'd0;
            pack      <= 32'h0;
            fill      <= 4'b0000;
          end
        end
        COLLECT: begin
          if (in_valid && remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
            pack      <= pack_next;
            fill      <= fill_next;
            lane      <= lane + 2'd1;
            if (word_ready) begin
              data_q <= pack_next;
              be_q   <= fill_next;
            end
          end
        end
        WRITE: begin
          addr_q <= addr_q + ADDR_W'(1);
          pack   <= 32'h0;
          fill   <= 4'b0000;
          lane   <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign address   = addr_q;
  assign writedata = data_q;

endmodule

// File: tb/tb_niosqsys_mem_byte_loader.sv
// Scoreboard bench for niosqsys_mem_byte_loader.
// The driver pushes expected writes and done latencies into queues.
// A negedge monitor pops from those queues and compares.
module tb_niosqsys_mem_byte_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [11:0] byte_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        busy;
  logic        done;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t        exp_wr[$];
  int         exp_lat[$];
  int         checks = 0;
  int         errors = 0;
  int         since_start = 0;
  int         busy_cnt = 0;
  logic [7:0] stim [16];

  niosqsys_mem_byte_loader #(.ADDR_W(10), .CNT_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.addr = 10'(a);
    w.data = d;
    w.be   = be;
    exp_wr.push_back(w);
  endtask

  // Monitor: compares every write strobe and done pulse against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (start && !busy) begin
        since_start = 0;
        busy_cnt    = 0;
      end else begin
        since_start++;
        if (busy) busy_cnt++;
      end
      if (write) begin
        if (exp_wr.size() == 0) begin
          check_output("unexpected_write", {22'h0, address, writedata}, 64'h0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check_output("write_word", {17'h0, chipselect, address, writedata, byteenable},
                       {17'h0, 1'b1, w.addr, w.data, w.be});
        end
      end
      if (done) begin
        if (exp_lat.size() == 0) begin
          check_output("unexpected_done", 64'h1, 64'h0);
        end else begin
          int lat;
          lat = exp_lat.pop_front();
          if (lat >= 0) check_output("done_latency", 64'(since_start), 64'(lat));
        end
      end
    end
  end

  // Drives one job; send < cnt leaves the job mid-stream without waiting for completion
  task automatic apply_job(input int base, input int cnt, input int send, input bit rnd, input bit repulse);
    int  i = 0;
    int  guard = 0;
    bit  xfer;
    @(posedge clk); #1;
    base_addr = 10'(base);
    byte_count = 12'(cnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 10'h3AA;
    byte_count = 12'd3;
    while (i < send && guard < 400) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = stim[i];
      if (repulse && i == 3) begin
        start = 1'b1;
        base_addr = 10'd77;
      end
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 400) check_output("stream_timeout", 64'(i), 64'(send));
    if (send == cnt) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (busy && guard < 50);
      if (guard >= 50) check_output("idle_timeout", 64'(busy), 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs",
                 {in_ready, chipselect, write, busy, done, byteenable, address, writedata}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    check_output("idle_after_reset", {in_ready, busy, done, write}, 64'h0);

    // Back-to-back 8 bytes from address 5
    for (int k = 0; k < 8; k++) stim[k] = 8'h11 + 8'(k);
    push_wr(5, 32'h14131211, 4'hF);
    push_wr(6, 32'h18171615, 4'hF);
    exp_lat.push_back(11);
    apply_job(5, 8, 8, 1'b0, 1'b0);

    // Six bytes: partial last word
    for (int k = 0; k < 6; k++) stim[k] = 8'hAA + 8'(k);
    push_wr(20, 32'hADACABAA, 4'hF);
    push_wr(21, 32'h0000AFAE, 4'h3);
    exp_lat.push_back(9);
    apply_job(20, 6, 6, 1'b0, 1'b0);

    // Address wrap from 1023 to 0
    for (int k = 0; k < 8; k++) stim[k] = 8'h31 + 8'(k);
    push_wr(1023, 32'h34333231, 4'hF);
    push_wr(0, 32'h38373635, 4'hF);
    exp_lat.push_back(11);
    apply_job(1023, 8, 8, 1'b0, 1'b0);

    // Zero-length job
    exp_lat.push_back(1);
    apply_job(50, 0, 0, 1'b0, 1'b0);
    check_output("zero_job_busy_cycles", 64'(busy_cnt), 64'd1);

    // Random stalls with a start re-pulse mid-job
    for (int k = 0; k < 8; k++) stim[k] = 8'h11 + 8'(k);
    push_wr(5, 32'h14131211, 4'hF);
    push_wr(6, 32'h18171615, 4'hF);
    exp_lat.push_back(-1);
    apply_job(5, 8, 8, 1'b1, 1'b1);

    // Reset after three of four bytes
    for (int k = 0; k < 4; k++) stim[k] = 8'h51 + 8'(k);
    apply_job(40, 4, 3, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_output("midjob_reset_outputs",
                 {in_ready, chipselect, write, busy, done, byteenable, address, writedata}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("idle_wait_after_reset", {in_ready, busy, write}, 64'h0);

    // Fresh job after reset
    for (int k = 0; k < 4; k++) stim[k] = 8'h21 + 8'(k);
    push_wr(100, 32'h24232221, 4'hF);
    exp_lat.push_back(6);
    apply_job(100, 4, 4, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_output("pending_writes", 64'(exp_wr.size()), 64'h0);
    check_output("pending_dones", 64'(exp_lat.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
